// File: rtl/vga_scanout_pkg.sv
// Shared timing defaults, FSM state type and RGB332 expansion for the VGA scanout block.
package vga_scanout_pkg;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned PIX_W = 8;
    localparam int unsigned CH_W  = 8;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_H_TOTAL      = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL      = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int unsigned DEF_H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb888_t;

    // Bit replication keeps full-scale codes at 8'hFF and zero at 8'h00.
    function automatic rgb888_t rgb332_to_rgb888(input logic [PIX_W-1:0] p);
        rgb888_t c;
        c.r = {p[7:5], p[7:5], p[7:6]};
        c.g = {p[4:2], p[4:2], p[4:3]};
        c.b = {p[1:0], p[1:0], p[1:0], p[1:0]};
        return c;
    endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Frame-buffer read port, control inputs and VGA pins of the scanout block.
interface vga_scanout_if;

    logic                                en;
    logic                                test_pattern;
    logic [vga_scanout_pkg::CNT_W-1:0]   r_x_address;
    logic [vga_scanout_pkg::CNT_W-1:0]   r_y_address;
    logic [vga_scanout_pkg::PIX_W-1:0]   data_out;
    logic [vga_scanout_pkg::CH_W-1:0]    vga_r;
    logic [vga_scanout_pkg::CH_W-1:0]    vga_g;
    logic [vga_scanout_pkg::CH_W-1:0]    vga_b;
    logic                                vga_hs;
    logic                                vga_vs;
    logic                                vga_blank_n;
    logic                                vga_sync_n;
    logic                                vblank;
    logic                                frame_start;

    // master: the scanout engine; slave: frame buffer plus control/display side
    modport master (
        input  en, test_pattern, data_out,
        output r_x_address, r_y_address, vga_r, vga_g, vga_b,
               vga_hs, vga_vs, vga_blank_n, vga_sync_n, vblank, frame_start
    );

    modport slave (
        output en, test_pattern, data_out,
        input  r_x_address, r_y_address, vga_r, vga_g, vga_b,
               vga_hs, vga_vs, vga_blank_n, vga_sync_n, vblank, frame_start
    );

endinterface

// File: rtl/vga_scanout_timing_counter.sv
// Raster h/v counters with visible window, raw active-low syncs and end-of-frame flag.
module vga_timing_counter
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             visible,
    output logic             hs_raw,
    output logic             vs_raw,
    output logic             wrap
);

    localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    logic h_last;
    logic v_last;

    assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_last = (v_cnt == CNT_W'(V_TOTAL - 1));

    // Counters sit at (0,0) whenever the scanout is stopped.
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
        end else begin
            h_cnt <= h_cnt + CNT_W'(1);
        end
    end

    assign visible = run && (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
    assign hs_raw  = !(run && (h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt <= CNT_W'(H_SYNC_END)));
    assign vs_raw  = !(run && (v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt <= CNT_W'(V_SYNC_END)));
    assign wrap    = run && h_last && v_last;

endmodule

// File: rtl/vga_scanout.sv
// VGA scanout: raster walk, frame-buffer read addressing and 2-clock colour/sync pipeline.
// Optional colour-bar generator enabled by defining VGA_SCANOUT_TEST_PATTERN_EN.
module vga_scanout
    import vga_scanout_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic          clk,
    input  logic          rst_n,
    vga_scanout_if.master bus
);

    state_t           state;
    logic             run;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             visible;
    logic             hs_raw;
    logic             vs_raw;
    logic             wrap;
    logic             vis_d1;
    logic             hs_d1;
    logic             vs_d1;
    rgb888_t          pix;

    assign run = (state != IDLE);

    vga_timing_counter #(
        .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
    ) u_timing (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .visible (visible),
        .hs_raw  (hs_raw),
        .vs_raw  (vs_raw),
        .wrap    (wrap)
    );

    // Dropping en mid-frame finishes the frame; dropping it on the last pixel stops at once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (bus.en) state <= ACTIVE;
                ACTIVE:  if (!bus.en) state <= wrap ? IDLE : DRAIN;
                DRAIN:   if (bus.en) state <= ACTIVE;
                         else if (wrap) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0: read address and writer-facing timing straight from the counters.
    assign bus.r_x_address = visible ? h_cnt : '0;
    assign bus.r_y_address = visible ? v_cnt : '0;
    assign bus.vblank      = !run || (v_cnt >= CNT_W'(V_VISIBLE));
    assign bus.frame_start = (state == ACTIVE) && (h_cnt == '0) && (v_cnt == '0);
    assign bus.vga_sync_n  = 1'b0;

    // Stage 1: align control with the frame buffer's one-clock read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vis_d1 <= 1'b0;
            hs_d1  <= 1'b1;
            vs_d1  <= 1'b1;
        end else begin
            vis_d1 <= visible;
            hs_d1  <= hs_raw;
            vs_d1  <= vs_raw;
        end
    end

`ifdef VGA_SCANOUT_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_VISIBLE / 8;

    logic [CNT_W-1:0] x_d1;
    logic [2:0]       bar;

    always_ff @(posedge clk) begin
        if (!rst_n) x_d1 <= '0;
        else        x_d1 <= h_cnt;
    end

    assign bar = 3'(x_d1 / CNT_W'(BAR_W));

    always_comb begin
        pix = rgb332_to_rgb888(bus.data_out);
        if (bus.test_pattern) begin
            pix.r = {CH_W{bar[2]}};
            pix.g = {CH_W{bar[1]}};
            pix.b = {CH_W{bar[0]}};
        end
    end
`else
    logic unused_test_pattern;
    assign unused_test_pattern = bus.test_pattern;

    always_comb begin
        pix = rgb332_to_rgb888(bus.data_out);
    end
`endif

    // Stage 2: registered pins; colour is forced black outside the visible window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.vga_r       <= '0;
            bus.vga_g       <= '0;
            bus.vga_b       <= '0;
            bus.vga_blank_n <= 1'b0;
            bus.vga_hs      <= 1'b1;
            bus.vga_vs      <= 1'b1;
        end else begin
            bus.vga_r       <= vis_d1 ? pix.r : '0;
            bus.vga_g       <= vis_d1 ? pix.g : '0;
            bus.vga_b       <= vis_d1 ? pix.b : '0;
            bus.vga_blank_n <= vis_d1;
            bus.vga_hs      <= hs_d1;
            bus.vga_vs      <= vs_d1;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout; vertical timing shortened to 15 lines so frames stay short.
module tb_vga_scanout;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] fill;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vga_scanout_if bus ();

    vga_scanout #(
        .V_VISIBLE (8), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Frame-buffer model: three marked pixels on row 0, everything else = fill.
    function automatic logic [7:0] fb_pix(input logic [9:0] x, input logic [9:0] y, input logic [7:0] f);
        if (y != 10'd0) return f;
        case (x)
            10'd5:   return 8'hE0;
            10'd6:   return 8'h1C;
            10'd7:   return 8'h03;
            default: return f;
        endcase
    endfunction

    always @(posedge clk) bus.data_out <= fb_pix(bus.r_x_address, bus.r_y_address, fill);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, bus.vga_r, bus.vga_g, bus.vga_b};
    endfunction

    function automatic logic [31:0] addr();
        return {12'h000, bus.r_x_address, bus.r_y_address};
    endfunction

    function automatic logic [31:0] xy(input int x, input int y);
        return {12'h000, 10'(x), 10'(y)};
    endfunction

    int hs_low, hs_first, vs_low, addr_err, vb_err, fs_extra, blank_err;

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b0;
        bus.test_pattern = 1'b0;
        fill = 8'h00;
        repeat (3) tick();
        chk("rst_hs",     32'(bus.vga_hs), 32'd1);
        chk("rst_vs",     32'(bus.vga_vs), 32'd1);
        chk("rst_blank",  32'(bus.vga_blank_n), 32'd0);
        chk("rst_rgb",    rgb(), 32'd0);
        chk("rst_sync_n", 32'(bus.vga_sync_n), 32'd0);
        chk("rst_addr",   addr(), 32'd0);
        chk("rst_vblank", 32'(bus.vblank), 32'd1);
        chk("rst_fs",     32'(bus.frame_start), 32'd0);

        rst_n = 1'b1;
        tick();
        chk("idle_vblank", 32'(bus.vblank), 32'd1);
        bus.en = 1'b1;
        tick();
        chk("fs_first",    32'(bus.frame_start), 32'd1);
        chk("addr_first",  addr(), 32'd0);
        chk("vblank_act",  32'(bus.vblank), 32'd0);

        // One full frame: addresses, vblank, syncs and pixel latency.
        hs_low = 0; hs_first = -1; vs_low = 0; addr_err = 0; vb_err = 0; fs_extra = 0; blank_err = 0;
        for (int c = 1; c < 12000; c++) begin
            int x, y;
            logic vis;
            tick();
            x = c % 800;
            y = c / 800;
            vis = (x < 640) && (y < 8);
            if (bus.r_x_address !== 10'(vis ? x : 0) || bus.r_y_address !== 10'(vis ? y : 0)) addr_err++;
            if (bus.vblank !== (y >= 8)) vb_err++;
            if (bus.frame_start !== 1'b0) fs_extra++;
            if (bus.vga_vs === 1'b0) vs_low++;
            if (c < 800 && bus.vga_hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = c;
            end
            if (c >= 642 && c < 800 && (bus.vga_blank_n !== 1'b0 || rgb() !== 32'd0)) blank_err++;
            if (c == 1)   chk("blank_c1", 32'(bus.vga_blank_n), 32'd0);
            if (c == 2)   chk("blank_c2", 32'(bus.vga_blank_n), 32'd1);
            if (c == 7)   chk("px_red",   rgb(), 32'h00FF0000);
            if (c == 8)   chk("px_green", rgb(), 32'h0000FF00);
            if (c == 9)   chk("px_blue",  rgb(), 32'h000000FF);
            if (c == 10)  chk("px_black", rgb(), 32'd0);
            if (c == 800) chk("addr_line1", addr(), xy(0, 1));
            if (c == 640) fill = 8'hFF;
        end
        tick();
        chk("fs_wrap",       32'(bus.frame_start), 32'd1);
        chk("addr_wrap",     addr(), 32'd0);
        chk("hs_low_line",   32'(hs_low), 32'd96);
        chk("hs_first_low",  32'(hs_first), 32'd658);
        chk("vs_low_frame",  32'(vs_low), 32'd1600);
        chk("addr_errors",   32'(addr_err), 32'd0);
        chk("vblank_errors", 32'(vb_err), 32'd0);
        chk("fs_extra",      32'(fs_extra), 32'd0);
        chk("blank_errors",  32'(blank_err), 32'd0);

        // en dropped at (100,5): frame completes, then IDLE.
        repeat (4100) tick();
        chk("drain_at", addr(), xy(100, 5));
        bus.en = 1'b0;
        repeat (100) tick();
        chk("drain_scan", addr(), xy(200, 5));
        repeat (7799) tick();
        chk("drain_last_vblank", 32'(bus.vblank), 32'd1);
        tick();
        chk("idle_after_fs",     32'(bus.frame_start), 32'd0);
        chk("idle_after_vblank", 32'(bus.vblank), 32'd1);
        repeat (2) tick();
        chk("idle_hs",    32'(bus.vga_hs), 32'd1);
        chk("idle_vs",    32'(bus.vga_vs), 32'd1);
        chk("idle_blank", 32'(bus.vga_blank_n), 32'd0);
        chk("idle_rgb",   rgb(), 32'd0);
        repeat (20) tick();
        chk("idle_hold_vblank", 32'(bus.vblank), 32'd1);
        chk("idle_hold_addr",   addr(), 32'd0);

        // Restart, drop en at (100,5), re-raise at (200,5): no gap, frame_start at next wrap.
        bus.en = 1'b1;
        tick();
        chk("restart_fs", 32'(bus.frame_start), 32'd1);
        repeat (4100) tick();
        bus.en = 1'b0;
        repeat (100) tick();
        bus.en = 1'b1;
        repeat (100) tick();
        chk("redrive_addr", addr(), xy(300, 5));
        repeat (7699) tick();
        chk("redrive_pre_fs", 32'(bus.frame_start), 32'd0);
        tick();
        chk("redrive_fs",     32'(bus.frame_start), 32'd1);
        chk("redrive_vblank", 32'(bus.vblank), 32'd0);

        // Synchronous reset mid-line at (300,3), then restart from (0,0).
        repeat (2700) tick();
        chk("pre_rst_addr",  addr(), xy(300, 3));
        chk("pre_rst_blank", 32'(bus.vga_blank_n), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_blank",  32'(bus.vga_blank_n), 32'd0);
        chk("mid_rst_rgb",    rgb(), 32'd0);
        chk("mid_rst_hs",     32'(bus.vga_hs), 32'd1);
        chk("mid_rst_vs",     32'(bus.vga_vs), 32'd1);
        chk("mid_rst_addr",   addr(), 32'd0);
        chk("mid_rst_vblank", 32'(bus.vblank), 32'd1);
        chk("mid_rst_fs",     32'(bus.frame_start), 32'd0);
        rst_n = 1'b1;
        bus.test_pattern = 1'b1;
        tick();
        chk("post_rst_fs",   32'(bus.frame_start), 32'd1);
        chk("post_rst_addr", addr(), 32'd0);

        // Colour bars when built with the pattern generator, frame-buffer data otherwise.
        repeat (87) tick();
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        chk("bar_x85", rgb(), 32'h000000FF);
`else
        chk("bar_x85", rgb(), 32'h00FFFFFF);
`endif
        repeat (315) tick();
`ifdef VGA_SCANOUT_TEST_PATTERN_EN
        chk("bar_x400", rgb(), 32'h00FF00FF);
`else
        chk("bar_x400", rgb(), 32'h00FFFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
